// File: rtl/vga_register_renderer.sv
// 640x480 VGA timing generator that renders an 11 x 16-bit register snapshot as hex glyphs.
// Outputs lag the counters by exactly 2 cycles; free-running, no backpressure.
module vga_register_renderer #(
  parameter logic [8:0] FG_COLOR = 9'b111_111_111,
  parameter logic [8:0] BG_COLOR = 9'b000_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [175:0] registersVGA,
  output logic         hs,
  output logic         vs,
  output logic [2:0]   r,
  output logic [2:0]   g,
  output logic [2:0]   b,
  output logic         frameStart
);

  localparam logic [9:0] H_LAST       = 10'd799;
  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_FIRST = 10'd656;
  localparam logic [9:0] H_SYNC_LAST  = 10'd751;
  localparam logic [9:0] V_LAST       = 10'd524;
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_FIRST = 10'd490;
  localparam logic [9:0] V_SYNC_LAST  = 10'd491;
  localparam logic [9:0] TEXT_W       = 10'd32;
  localparam logic [9:0] TEXT_H       = 10'd176;
  localparam int         NUM_REGS     = 11;

  // 5x7 font, each font row doubled to fill glyph rows 1..14; bit 7 is the leftmost pixel.
  function automatic logic [7:0] glyph_row(input logic [3:0] code, input logic [3:0] line);
    logic [34:0] bmp;
    logic [2:0]  frow;
    logic [7:0]  row;
    bmp = '0;
    row = '0;
    case (code)
      4'h0:    bmp = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
      4'h1:    bmp = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      4'h2:    bmp = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
      4'h3:    bmp = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
      4'h4:    bmp = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
      4'h5:    bmp = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
      4'h6:    bmp = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
      4'h7:    bmp = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
      4'h8:    bmp = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
      4'h9:    bmp = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
      4'hA:    bmp = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11};
      4'hB:    bmp = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E};
      4'hC:    bmp = {5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E};
      4'hD:    bmp = {5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C};
      4'hE:    bmp = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
      default: bmp = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10};
    endcase
    frow = 3'((line - 4'd1) >> 1);
    if (line != 4'd0 && line != 4'd15) begin
      row = {1'b0, bmp[34 - 5*frow -: 5], 2'b00};
    end
    return row;
  endfunction

  logic [9:0]   hcnt;
  logic [9:0]   vcnt;
  logic [175:0] snapshot;

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  // Taken at the start of vertical blanking so each frame renders from one consistent value.
  always_ff @(posedge clk) begin
    if (rst) begin
      snapshot <= '0;
    end else if (hcnt == 10'd0 && vcnt == V_VISIBLE) begin
      snapshot <= registersVGA;
    end
  end

  logic [15:0] cell_reg;
  logic [3:0]  cell_code;
  logic        visible;
  logic        in_text;
  logic        hs_raw;
  logic        vs_raw;
  logic        fs_raw;

  always_comb begin
    cell_reg = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (vcnt[7:4] == 4'(i)) cell_reg = snapshot[175 - 16*i -: 16];
    end
    case (hcnt[4:3])
      2'd0:    cell_code = cell_reg[15:12];
      2'd1:    cell_code = cell_reg[11:8];
      2'd2:    cell_code = cell_reg[7:4];
      default: cell_code = cell_reg[3:0];
    endcase
    visible = (hcnt < H_VISIBLE) && (vcnt < V_VISIBLE);
    in_text = (hcnt < TEXT_W) && (vcnt < TEXT_H);
    hs_raw  = !((hcnt >= H_SYNC_FIRST) && (hcnt <= H_SYNC_LAST));
    vs_raw  = !((vcnt >= V_SYNC_FIRST) && (vcnt <= V_SYNC_LAST));
    fs_raw  = (hcnt == 10'd0) && (vcnt == 10'd0);
  end

  logic [7:0] s1_glyph;
  logic [2:0] s1_col;
  logic       s1_vis;
  logic       s1_text;
  logic       s1_hs;
  logic       s1_vs;
  logic       s1_fs;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_glyph <= '0;
      s1_col   <= '0;
      s1_vis   <= 1'b0;
      s1_text  <= 1'b0;
      s1_hs    <= 1'b1;
      s1_vs    <= 1'b1;
      s1_fs    <= 1'b0;
    end else begin
      s1_glyph <= glyph_row(cell_code, vcnt[3:0]);
      s1_col   <= hcnt[2:0];
      s1_vis   <= visible;
      s1_text  <= in_text;
      s1_hs    <= hs_raw;
      s1_vs    <= vs_raw;
      s1_fs    <= fs_raw;
    end
  end

  logic [8:0] colour;

  always_comb begin
    colour = '0;
    if (s1_vis) begin
      colour = (s1_text && s1_glyph[3'd7 - s1_col]) ? FG_COLOR : BG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {r, g, b}  <= '0;
      hs         <= 1'b1;
      vs         <= 1'b1;
      frameStart <= 1'b0;
    end else begin
      {r, g, b}  <= colour;
      hs         <= s1_hs;
      vs         <= s1_vs;
      frameStart <= s1_fs;
    end
  end

endmodule

// File: tb/tb_vga_register_renderer.sv
// Directed bench for vga_register_renderer: timing, glyph rendering, snapshot and reset behaviour.
module tb_vga_register_renderer;

  localparam logic [8:0] FG = 9'h1FF;
  localparam logic [8:0] BG = 9'h053;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [175:0] regs = '0;
  logic         hs;
  logic         vs;
  logic         frameStart;
  logic [2:0]   r;
  logic [2:0]   g;
  logic [2:0]   b;

  vga_register_renderer #(.FG_COLOR(FG), .BG_COLOR(BG)) dut (
    .clk(clk), .rst(rst), .registersVGA(regs),
    .hs(hs), .vs(vs), .r(r), .g(g), .b(b), .frameStart(frameStart)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         h;
    int         v;
    logic [8:0] rgb;
    logic       hs;
    logic       vs;
  } vec_t;

  vec_t         vecs[$];
  int           n_checks;
  int           n_pass;
  int           cyc;
  int           th;
  int           tv;
  int           jcyc;
  logic [175:0] msnap;
  logic [9:0]   jh;
  logic [9:0]   jv;
  logic         prev_hs = 1'b1;
  logic         prev_vs = 1'b1;
  int           hs_falls[$];
  int           hs_rises[$];
  int           vs_falls[$];
  int           vs_rises[$];
  int           fs_hits[$];

  function automatic logic [4:0] font(input logic [3:0] nib, input int row);
    logic [34:0] bmp;
    case (nib)
      4'h0:    bmp = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
      4'h1:    bmp = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      4'h2:    bmp = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
      4'h3:    bmp = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
      4'h4:    bmp = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
      4'h5:    bmp = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
      4'h6:    bmp = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
      4'h7:    bmp = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
      4'h8:    bmp = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
      4'h9:    bmp = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
      4'hA:    bmp = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11};
      4'hB:    bmp = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E};
      4'hC:    bmp = {5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E};
      4'hD:    bmp = {5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C};
      4'hE:    bmp = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
      default: bmp = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10};
    endcase
    return bmp[34 - 5*row -: 5];
  endfunction

  // Expected colour at screen position (h,v) for a given register snapshot.
  function automatic logic [8:0] exp_rgb(input int h, input int v, input logic [175:0] s);
    logic [15:0] sl;
    logic [3:0]  nib;
    logic [4:0]  f;
    int          fr;
    int          px;
    if (h >= 640 || v >= 480) return 9'h000;
    if (h >= 32 || v >= 176) return BG;
    sl  = s[175 - 16*(v/16) -: 16];
    nib = sl[15 - 4*(h/8) -: 4];
    fr  = v % 16;
    px  = h % 8;
    if (fr == 0 || fr == 15 || px < 1 || px > 5) return BG;
    f = font(nib, (fr - 1) / 2);
    return f[5 - px] ? FG : BG;
  endfunction

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_log();
    hs_falls.delete(); hs_rises.delete();
    vs_falls.delete(); vs_rises.delete();
    fs_hits.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (prev_hs && !hs) hs_falls.push_back(cyc);
    if (!prev_hs && hs) hs_rises.push_back(cyc);
    if (prev_vs && !vs) vs_falls.push_back(cyc);
    if (!prev_vs && vs) vs_rises.push_back(cyc);
    if (frameStart) fs_hits.push_back(cyc);
    prev_hs = hs;
    prev_vs = vs;
    th++;
    if (th == 800) begin
      th = 0;
      tv = (tv == 524) ? 0 : tv + 1;
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, want, want);
  endtask

  // Moves the counters to (h,v); outputs reflect that position two ticks later.
  task automatic jump(input int h, input int v);
    jh = 10'(h);
    jv = 10'(v);
    force dut.hcnt = jh;
    force dut.vcnt = jv;
    release dut.hcnt;
    release dut.vcnt;
    tick();
    tick();
    th = h;
    tv = v;
  endtask

  task automatic run_span(input string name, input int n);
    int nmis, fh, fv;
    logic [8:0] grgb, wrgb, ergb;
    logic ghs, gvs, gfs, whs, wvs, wfs, ehs, evs, efs;
    nmis = 0; fh = 0; fv = 0;
    grgb = '0; wrgb = '0; ghs = 0; gvs = 0; gfs = 0; whs = 0; wvs = 0; wfs = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      ergb = exp_rgb(th, tv, msnap);
      ehs  = !(th >= 656 && th <= 751);
      evs  = !(tv >= 490 && tv <= 491);
      efs  = (th == 0 && tv == 0);
      if ({r, g, b} !== ergb || hs !== ehs || vs !== evs || frameStart !== efs) begin
        if (nmis == 0) begin
          fh = th; fv = tv; grgb = {r, g, b}; ghs = hs; gvs = vs; gfs = frameStart;
          wrgb = ergb; whs = ehs; wvs = evs; wfs = efs;
        end
        nmis++;
      end
    end
    n_checks++;
    if (nmis == 0) n_pass++;
    else $display("FAIL %s: %0d bad cycles, first at h=%0d v=%0d got rgb=%h hs=%b vs=%b fs=%b, expected rgb=%h hs=%b vs=%b fs=%b",
                  name, nmis, fh, fv, grgb, ghs, gvs, gfs, wrgb, whs, wvs, wfs);
  endtask

  task automatic add_vec(input int h, input int v, input logic [8:0] rgb, input logic hs_e, input logic vs_e);
    vec_t t;
    t.h = h; t.v = v; t.rgb = rgb; t.hs = hs_e; t.vs = vs_e;
    vecs.push_back(t);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; th = 0; tv = 0; jcyc = 0;
    msnap = '0;
    // R0=A5C3, rest zero: hand-derived pixels of frame 1, in raster order.
    add_vec(0, 0, BG, 1, 1);      add_vec(1, 1, BG, 1, 1);      add_vec(3, 1, FG, 1, 1);
    add_vec(9, 1, FG, 1, 1);      add_vec(17, 1, BG, 1, 1);     add_vec(18, 1, FG, 1, 1);
    add_vec(25, 1, FG, 1, 1);     add_vec(30, 1, BG, 1, 1);     add_vec(32, 3, BG, 1, 1);
    add_vec(1, 5, FG, 1, 1);      add_vec(3, 5, BG, 1, 1);      add_vec(5, 5, FG, 1, 1);
    add_vec(9, 5, FG, 1, 1);      add_vec(13, 5, BG, 1, 1);     add_vec(31, 13, BG, 1, 1);
    add_vec(2, 15, BG, 1, 1);     add_vec(1, 17, BG, 1, 1);     add_vec(2, 17, FG, 1, 1);
    add_vec(1, 19, FG, 1, 1);     add_vec(639, 20, BG, 1, 1);   add_vec(640, 20, 9'h0, 1, 1);
    add_vec(655, 20, 9'h0, 1, 1); add_vec(656, 20, 9'h0, 0, 1); add_vec(751, 20, 9'h0, 0, 1);
    add_vec(752, 20, 9'h0, 1, 1);

    // Live bus non-zero from the start: frame 0 must still render from the cleared snapshot.
    regs = {11{16'hFFFF}};
    rst  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("reset_outputs", int'({hs, vs, r, g, b, frameStart}), 32'hC00);
    end
    rst = 1'b0;
    clear_log();
    cyc = 0;
    tick();
    check_val("release_first_cycle", int'({hs, vs, r, g, b, frameStart}), 32'hC00);
    th = 799; tv = 524;
    run_span("frame0_zero_glyphs", 17 * 800);
    check_val("first_frameStart", qat(fs_hits, 0), 2);
    check_val("frameStart_count", fs_hits.size(), 1);
    check_val("first_hs_fall", qat(hs_falls, 0), 658);
    check_val("hs_period", qat(hs_falls, 1) - qat(hs_falls, 0), 800);
    check_val("hs_low_len", qat(hs_rises, 0) - qat(hs_falls, 0), 96);

    regs = '0;
    regs[175:160] = 16'hA5C3;
    jump(790, 479);
    run_span("capture_line", 30);
    msnap = regs;

    clear_log();
    jump(790, 489);
    run_span("vsync_window", 10 + 3 * 800 + 10);
    check_val("vs_fall_count", vs_falls.size(), 1);
    check_val("vs_low_len", qat(vs_rises, 0) - qat(vs_falls, 0), 1600);

    clear_log();
    jcyc = cyc;
    jump(790, 524);
    run_span("frame_wrap", 10);
    check_val("wrap_frameStart_latency", qat(fs_hits, 0) - jcyc, 12);

    for (int i = 0; i < vecs.size(); i++) begin
      int guard;
      guard = 0;
      while (!(th == vecs[i].h && tv == vecs[i].v) && guard < 420000) begin
        tick();
        guard++;
      end
      n_checks++;
      if ({r, g, b} === vecs[i].rgb && hs === vecs[i].hs && vs === vecs[i].vs) n_pass++;
      else $display("FAIL vec%0d (h=%0d v=%0d): got rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                    i, vecs[i].h, vecs[i].v, {r, g, b}, hs, vs, vecs[i].rgb, vecs[i].hs, vecs[i].vs);
    end

    // Bus changes mid-frame; the rest of this frame must keep the old snapshot.
    regs = '0;
    regs[175:160] = 16'h1234;
    regs[159:144] = 16'hFFFF;
    run_span("no_tear_rest_of_frame", 14 * 800);
    jump(790, 479);
    run_span("capture_second", 20);
    msnap = regs;
    jump(790, 524);
    run_span("frame2_new_value", 10 + 20 * 800);

    jump(290, 200);
    run_span("before_midframe_reset", 8);
    rst = 1'b1;
    tick();
    check_val("midframe_reset_outputs", int'({hs, vs, r, g, b, frameStart}), 32'hC00);
    rst = 1'b0;
    clear_log();
    cyc = 0;
    tick();
    check_val("midframe_release_first_cycle", int'({hs, vs, r, g, b, frameStart}), 32'hC00);
    th = 799; tv = 524;
    run_span("restart_from_origin", 700);
    check_val("restart_frameStart", qat(fs_hits, 0), 2);
    check_val("restart_hs_fall", qat(hs_falls, 0), 658);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
